// File: rtl/aer_pkg.sv
// aer_pkg: shared constants and the address-event record for the spike AER encoder
package aer_pkg;
  localparam int N_NEURONS_DEF = 8;
  localparam int TS_WIDTH_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int DROP_CNT_W = 8;
  localparam int ADDR_W = $clog2(N_NEURONS_DEF);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TS_WIDTH_DEF-1:0] ts;
  } aer_event_t;
endpackage

// File: rtl/aer_fifo.sv
// aer_fifo: sync FIFO of events; ports clk, reset_n (sync active-low), push/din, pop/dout, full, empty
module aer_fifo
  import aer_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter type T = aer_event_t
) (
  input  logic clk,
  input  logic reset_n,
  input  logic push,
  input  T     din,
  input  logic pop,
  output T     dout,
  output logic full,
  output logic empty
);
  localparam int PW = $clog2(DEPTH);
  T mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic do_push, do_pop;
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/spike_aer_encoder.sv
// spike_aer_encoder: spike rising edges -> round-robin arbitrated {addr,ts} events over valid/ready; clk, reset_n, spike_in, ts_tick, aer_*, drop_count, fifo_full
module spike_aer_encoder
  import aer_pkg::*;
#(
  parameter int N_NEURONS = N_NEURONS_DEF,
  parameter int TS_WIDTH = TS_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int AW = $clog2(N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N_NEURONS-1:0]  spike_in,
  input  logic                  ts_tick,
  output logic                  aer_valid,
  input  logic                  aer_ready,
  output logic [AW-1:0]         aer_addr,
  output logic [TS_WIDTH-1:0]   aer_ts,
  output logic [DROP_CNT_W-1:0] drop_count,
  output logic                  fifo_full
);
  localparam int DROP_MAX = (1 << DROP_CNT_W) - 1;
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [TS_WIDTH-1:0] ts;
  } ev_t;
  logic [N_NEURONS-1:0] spike_q, pending, rise, gnt_oh, drop;
  logic [AW-1:0] rr_ptr, gnt_idx, idx;
  logic [TS_WIDTH-1:0] ts;
  logic [DROP_CNT_W-1:0] drop_nx;
  logic gnt_any, empty;
  int dsum;
  ev_t head, push_ev;
  assign rise = spike_in & ~spike_q;
  assign drop = rise & pending & ~gnt_oh;
  assign push_ev = '{addr: gnt_idx, ts: ts};
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    idx = rr_ptr;
    for (int k = N_NEURONS; k >= 1; k--) begin
      idx = rr_ptr + AW'(k);
      if (pending[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    gnt_any = gnt_any && !fifo_full;
    gnt_oh = gnt_any ? (N_NEURONS'(1) << gnt_idx) : '0;
  end
  always_comb begin
    dsum = int'(drop_count) + $countones(drop);
    drop_nx = dsum > DROP_MAX ? DROP_CNT_W'(DROP_MAX) : DROP_CNT_W'(dsum);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spike_q <= '0;
      pending <= '0;
      rr_ptr <= AW'(N_NEURONS - 1);
      ts <= '0;
      drop_count <= '0;
    end else begin
      spike_q <= spike_in;
      pending <= rise | (pending & ~gnt_oh);
      if (gnt_any) rr_ptr <= gnt_idx;
      ts <= ts + TS_WIDTH'(ts_tick);
      drop_count <= drop_nx;
    end
  end
  aer_fifo #(.DEPTH(FIFO_DEPTH), .T(ev_t)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(gnt_any),
    .din(push_ev),
    .pop(aer_ready),
    .dout(head),
    .full(fifo_full),
    .empty(empty)
  );
  assign aer_valid = !empty;
  assign aer_addr = empty ? '0 : head.addr;
  assign aer_ts = empty ? '0 : head.ts;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// tb_spike_aer_encoder: randomized and directed checks of spike_aer_encoder against a queue-based event model
module tb_spike_aer_encoder;
  localparam int N = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ts_tick = 1'b0;
  logic aer_ready = 1'b0;
  logic [7:0] spike_in = '0;
  logic aer_valid, fifo_full;
  logic [2:0] aer_addr;
  logic [7:0] aer_ts, drop_count;
  int n_tests = 0;
  int n_fail = 0;
  bit m_pend [N];
  int m_rr, m_ts, m_drop;
  logic [7:0] m_sq;
  int m_q [$];
  int got [$];

  always #5 clk = ~clk;

  spike_aer_encoder dut (
    .clk(clk),
    .reset_n(reset_n),
    .spike_in(spike_in),
    .ts_tick(ts_tick),
    .aer_valid(aer_valid),
    .aer_ready(aer_ready),
    .aer_addr(aer_addr),
    .aer_ts(aer_ts),
    .drop_count(drop_count),
    .fifo_full(fifo_full)
  );

  function automatic logic [20:0] obs();
    return {aer_valid, aer_addr, aer_ts, fifo_full, drop_count};
  endfunction

  function automatic logic [20:0] expv();
    int h;
    h = m_q.size() != 0 ? m_q[0] : 0;
    return {m_q.size() != 0, 3'(h >> 8), 8'(h), m_q.size() == D, 8'(m_drop)};
  endfunction

  task automatic model_step();
    int g;
    bit r;
    g = -1;
    if (!reset_n) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_rr = N - 1;
      m_ts = 0;
      m_drop = 0;
      m_sq = '0;
      m_q.delete();
      return;
    end
    if (m_q.size() < D)
      for (int k = 1; k <= N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    for (int i = 0; i < N; i++) begin
      r = spike_in[i] && !m_sq[i];
      if (r && m_pend[i] && g != i) m_drop = m_drop < 255 ? m_drop + 1 : 255;
      m_pend[i] = r || (m_pend[i] && g != i);
    end
    if (m_q.size() != 0 && aer_ready) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(g * 256 + m_ts);
      m_rr = g;
    end
    m_ts = (m_ts + int'(ts_tick)) % 256;
    m_sq = spike_in;
  endtask

  task automatic tick();
    if (aer_valid && aer_ready) got.push_back(int'({aer_addr, aer_ts}));
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    spike_in = '0;
    tick();
    reset_n = 1'b1;
    got.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    spike_in = '0;
    repeat (3) tick();
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), 21'd0);
    end
    reset_n = 1'b1;
    got.delete();
  endtask

  task automatic test_single();
    ts_tick = 1'b1;
    aer_ready = 1'b1;
    spike_in = 8'h04;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL single cyc %0d: got %h expected %h", c, obs(), expv());
      end
      if (c == 1) begin
        n_tests++;
        if (aer_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_latency1: valid %b expected 0", aer_valid);
        end
      end
      if (c == 2) begin
        n_tests++;
        if ({aer_valid, aer_addr, aer_ts} !== {1'b1, 3'd2, 8'd1}) begin
          n_fail++;
          $display("FAIL single_latency2: valid/addr/ts %b/%0d/%0d expected 1/2/1", aer_valid, aer_addr, aer_ts);
        end
      end
    end
    spike_in = '0;
    repeat (3) tick();
    n_tests++;
    if (got.size() != 1 || got[0] >> 8 != 2 || drop_count !== 8'd0) begin
      n_fail++;
      $display("FAIL single_count: events %0d drop %0d expected 1 event addr 2 drop 0", got.size(), drop_count);
    end
  endtask

  task automatic test_pair();
    int exp_a [4] = '{0, 7, 0, 7};
    do_reset();
    aer_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      spike_in = 8'h81;
      repeat (6) begin
        tick();
        n_tests++;
        if (obs() !== expv()) begin
          n_fail++;
          $display("FAIL pair round %0d: got %h expected %h", r, obs(), expv());
        end
      end
      spike_in = '0;
      repeat (2) tick();
    end
    tick();
    n_tests++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL pair_count: got %0d events expected 4", got.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ((got.size() > i ? got[i] >> 8 : -1) != exp_a[i]) begin
        n_fail++;
        $display("FAIL pair_order[%0d]: got %0d expected %0d", i, got.size() > i ? got[i] >> 8 : -1, exp_a[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [20:0] held;
    do_reset();
    aer_ready = 1'b0;
    ts_tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      spike_in[i] = 1'b1;
      tick();
    end
    repeat (2) tick();
    n_tests++;
    if ({fifo_full, drop_count} !== {1'b1, 8'd0} || !m_pend[4] || !m_pend[5]) begin
      n_fail++;
      $display("FAIL overflow_full: full %b drop %0d expected 1 and 0", fifo_full, drop_count);
    end
    spike_in[4] = 1'b0;
    tick();
    spike_in[4] = 1'b1;
    tick();
    n_tests++;
    if (drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL overflow_drop: drop %0d expected 1", drop_count);
    end
    held = obs();
    repeat (5) begin
      tick();
      n_tests++;
      if (obs() !== held || aer_addr !== 3'd0 || obs() !== expv()) begin
        n_fail++;
        $display("FAIL overflow_hold: got %h expected %h", obs(), held);
      end
    end
    aer_ready = 1'b1;
    repeat (12) begin
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL overflow_drain: got %h expected %h", obs(), expv());
      end
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if ((got.size() > i ? got[i] >> 8 : -1) != i) begin
        n_fail++;
        $display("FAIL overflow_order[%0d]: got %0d expected %0d", i, got.size() > i ? got[i] >> 8 : -1, i);
      end
    end
    n_tests++;
    if (got.size() != 6 || drop_count !== 8'd1) begin
      n_fail++;
      $display("FAIL overflow_total: events %0d drop %0d expected 6 and 1", got.size(), drop_count);
    end
  endtask

  task automatic test_saturate();
    int prev;
    do_reset();
    aer_ready = 1'b0;
    spike_in = 8'h0F;
    repeat (6) tick();
    prev = 0;
    for (int c = 0; c < 600; c++) begin
      spike_in[3] = ~spike_in[3];
      tick();
      n_tests++;
      if (obs() !== expv() || int'(drop_count) < prev) begin
        n_fail++;
        $display("FAIL saturate cyc %0d: got %h expected %h", c, obs(), expv());
      end
      prev = int'(drop_count);
    end
    n_tests++;
    if (drop_count !== 8'd255) begin
      n_fail++;
      $display("FAIL saturate_final: drop %0d expected 255", drop_count);
    end
  endtask

  task automatic test_ts_wrap();
    int exp_t [5] = '{255, 0, 1, 2, 3};
    do_reset();
    aer_ready = 1'b1;
    for (int c = 0; c < 1100; c++) begin
      ts_tick = (c % 4 == 0);
      spike_in = (c > 600 && c % 4 == 1 && (m_ts == 255 || m_ts <= 3)) ? 8'h02 : 8'h00;
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL ts_wrap cyc %0d: got %h expected %h", c, obs(), expv());
      end
    end
    n_tests++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL ts_wrap_count: got %0d events expected 5", got.size());
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ((got.size() > i ? got[i] : -1) != 256 + exp_t[i]) begin
        n_fail++;
        $display("FAIL ts_wrap_ev[%0d]: got %0d expected addr 1 ts %0d", i, got.size() > i ? got[i] : -1, exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    aer_ready = 1'b0;
    ts_tick = 1'b1;
    spike_in = 8'h07;
    repeat (5) tick();
    n_tests++;
    if (aer_valid !== 1'b1 || m_q.size() != 3) begin
      n_fail++;
      $display("FAIL reset_mid_pre: valid %b expected 1", aer_valid);
    end
    aer_ready = 1'b1;
    do_reset();
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got %h expected %h", obs(), 21'd0);
    end
    spike_in = 8'h40;
    repeat (5) begin
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL reset_mid_run: got %h expected %h", obs(), expv());
      end
    end
    n_tests++;
    if (got.size() != 1 || got[0] >> 8 != 6 || (got[0] & 255) > 1) begin
      n_fail++;
      $display("FAIL reset_mid_event: events %0d first %0d expected addr 6 ts 0/1", got.size(), got.size() ? got[0] : -1);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 2500; c++) begin
      spike_in = spike_in ^ 8'($urandom & $urandom & $urandom);
      ts_tick = 1'($urandom);
      aer_ready = ($urandom % 4) != 0;
      if (c % 700 == 699) aer_ready = 1'b0;
      tick();
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h expected %h", c, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_pair();
    test_overflow();
    test_saturate();
    test_ts_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
